// File: rtl/ltl_nfa_monitor.sv
// Homogeneous-automaton (STE/NFA) trace monitor: per-symbol match table, state-to-state
// edges, start-of-data / all-input start states and a report FIFO with sticky overflow.
module ltl_nfa_monitor #(
  parameter int N_STATES   = 16,
  parameter int SYM_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OFS_W      = 16,
  localparam int IDX_W     = (N_STATES > 1) ? $clog2(N_STATES) : 1,
  localparam int ROW_W     = (SYM_W > IDX_W) ? SYM_W : IDX_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                sym_valid,
  input  logic [SYM_W-1:0]    symbol,
  input  logic                flush,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic [ROW_W-1:0]    cfg_row,
  input  logic [IDX_W-1:0]    cfg_col,
  input  logic [1:0]          cfg_val,
  output logic [N_STATES-1:0] active_state,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [N_STATES-1:0] rpt_vec,
  output logic [OFS_W-1:0]    rpt_offset,
  output logic                rpt_overflow
);

  localparam int N_SYM = 1 << SYM_W;

  logic [N_STATES-1:0] match_r [N_SYM];
  logic [N_STATES-1:0] edge_r  [N_STATES];
  logic [N_STATES-1:0] sod_start_r, all_start_r, rpt_mask_r;
  logic [N_STATES-1:0] active_r, reach_s, nxt_s, hit_s;
  logic [OFS_W-1:0]    offset_r;
  logic                sod_r, step_s, push_s, pop_s, ovf_s, overflow_r;
  logic                row_ok_s, col_ok_s;

  logic [N_STATES-1:0]   fifo_vec_r [FIFO_DEPTH];
  logic [OFS_W-1:0]      fifo_ofs_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld_r;
  logic [N_STATES-1:0]   nvec_s     [FIFO_DEPTH];
  logic [OFS_W-1:0]      nofs_s     [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] shf_vld_s, slot_s, nvld_s;

  // Configuration write address range checks
  always_comb begin
    row_ok_s = (32'(cfg_row) < 32'(N_STATES));
    col_ok_s = (32'(cfg_col) < 32'(N_STATES));
  end

  // Configuration tables, writable only while the monitor is stopped
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < N_SYM; s++) match_r[s] <= '0;
      for (int i = 0; i < N_STATES; i++) edge_r[i] <= '0;
      sod_start_r <= '0;
      all_start_r <= '0;
      rpt_mask_r  <= '0;
    end else if (cfg_we && !run) begin
      case (cfg_sel)
        2'd0: if (col_ok_s) match_r[cfg_row[SYM_W-1:0]][cfg_col] <= cfg_val[0];
        2'd1: if (row_ok_s && col_ok_s) edge_r[cfg_row[IDX_W-1:0]][cfg_col] <= cfg_val[0];
        2'd2: if (row_ok_s) begin
          sod_start_r[cfg_row[IDX_W-1:0]] <= cfg_val[0];
          all_start_r[cfg_row[IDX_W-1:0]] <= cfg_val[1];
        end
        2'd3: if (row_ok_s) rpt_mask_r[cfg_row[IDX_W-1:0]] <= cfg_val[0];
        default: ;
      endcase
    end
  end

  // Next active set: a state fires when it matches and is started or reached by an edge
  always_comb begin
    step_s  = run & sym_valid;
    reach_s = '0;
    for (int j = 0; j < N_STATES; j++) begin
      reach_s = reach_s | ({N_STATES{active_r[j]}} & edge_r[j]);
    end
    nxt_s  = match_r[symbol] & (({N_STATES{sod_r}} & sod_start_r) | all_start_r | reach_s);
    hit_s  = nxt_s & rpt_mask_r;
    push_s = step_s & (|hit_s);
  end

  // Shift-register FIFO so the head entry is always a register; a pop frees a slot for a push
  always_comb begin
    pop_s = fifo_vld_r[0] & rpt_ready;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      nvec_s[k] = fifo_vec_r[k];
      nofs_s[k] = fifo_ofs_r[k];
    end
    if (pop_s) begin
      for (int k = 0; k < FIFO_DEPTH - 1; k++) begin
        nvec_s[k] = fifo_vec_r[k+1];
        nofs_s[k] = fifo_ofs_r[k+1];
      end
      shf_vld_s = {1'b0, fifo_vld_r[FIFO_DEPTH-1:1]};
    end else begin
      shf_vld_s = fifo_vld_r;
    end
    slot_s = ~shf_vld_s & {shf_vld_s[FIFO_DEPTH-2:0], 1'b1};
    if (push_s && !shf_vld_s[FIFO_DEPTH-1]) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        nvec_s[k] = slot_s[k] ? hit_s : nvec_s[k];
        nofs_s[k] = slot_s[k] ? offset_r : nofs_s[k];
      end
      nvld_s = shf_vld_s | slot_s;
      ovf_s  = overflow_r;
    end else begin
      nvld_s = shf_vld_s;
      ovf_s  = overflow_r | push_s;
    end
  end

  // Run-time state; flush clears everything except the configuration
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      active_r   <= '0;
      offset_r   <= '0;
      sod_r      <= 1'b1;
      overflow_r <= 1'b0;
      fifo_vld_r <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_vec_r[k] <= '0;
        fifo_ofs_r[k] <= '0;
      end
    end else begin
      if (step_s) begin
        active_r <= nxt_s;
        offset_r <= offset_r + OFS_W'(1);
        sod_r    <= 1'b0;
      end
      fifo_vld_r <= nvld_s;
      overflow_r <= ovf_s;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_vec_r[k] <= nvec_s[k];
        fifo_ofs_r[k] <= nofs_s[k];
      end
    end
  end

  assign active_state = active_r;
  assign rpt_valid    = fifo_vld_r[0];
  assign rpt_vec      = fifo_vec_r[0];
  assign rpt_offset   = fifo_ofs_r[0];
  assign rpt_overflow = overflow_r;

endmodule

// File: tb/tb_ltl_nfa_monitor.sv
// Self-checking bench for ltl_nfa_monitor: directed table, hand sequences for FIFO/offset
// corner cases, and a randomized run against a set/queue-based reference model.
module tb_ltl_nfa_monitor;
  localparam int N = 4, SW = 8, FD = 2, OW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, run, sym_valid, flush, cfg_we, rpt_ready;
  logic [7:0] symbol, cfg_row;
  logic [1:0] cfg_sel, cfg_col, cfg_val;
  logic [3:0] active_state, rpt_vec, rpt_offset;
  logic       rpt_valid, rpt_overflow;

  ltl_nfa_monitor #(.N_STATES(N), .SYM_W(SW), .FIFO_DEPTH(FD), .OFS_W(OW)) dut (
    .clk(clk), .reset(reset), .run(run), .sym_valid(sym_valid), .symbol(symbol),
    .flush(flush), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_row(cfg_row),
    .cfg_col(cfg_col), .cfg_val(cfg_val), .active_state(active_state),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_vec(rpt_vec),
    .rpt_offset(rpt_offset), .rpt_overflow(rpt_overflow)
  );

  int n_cmp = 0, n_fail = 0;

  // Reference model: sets of states, a queue of reports.
  typedef struct { bit [3:0] vec; int ofs; } rpt_t;
  bit       m_match [N][256];
  bit [3:0] m_edge  [N];
  bit [3:0] m_sod_st, m_all_st, m_mask, m_act;
  int       m_ofs;
  bit       m_sod, m_ovf;
  rpt_t     m_q[$];

  typedef struct {
    logic run, sv; logic [7:0] sym; logic fl, rr;
    logic [3:0] e_act; logic e_rv; logic [3:0] e_vec; logic [3:0] e_ofs; logic e_ovf;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < 256; s++) m_match[i][s] = 1'b0;
      m_edge[i] = 4'd0;
    end
    m_sod_st = 4'd0; m_all_st = 4'd0; m_mask = 4'd0; m_act = 4'd0;
    m_ofs = 0; m_sod = 1'b1; m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_clock();
    bit [3:0] nv, rv;
    bit pop, push, reached;
    rpt_t e;
    nv = 4'd0; push = 1'b0; e.vec = 4'd0; e.ofs = 0;
    if (cfg_we && !run) begin
      case (cfg_sel)
        2'd0: m_match[cfg_col][cfg_row] = cfg_val[0];
        2'd1: if (cfg_row < 8'd4) m_edge[cfg_row][cfg_col] = cfg_val[0];
        2'd2: if (cfg_row < 8'd4) begin
          m_sod_st[cfg_row] = cfg_val[0];
          m_all_st[cfg_row] = cfg_val[1];
        end
        default: if (cfg_row < 8'd4) m_mask[cfg_row] = cfg_val[0];
      endcase
    end
    if (flush) begin
      m_act = 4'd0; m_ofs = 0; m_sod = 1'b1; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      pop = (m_q.size() > 0) && rpt_ready;
      if (run && sym_valid) begin
        for (int i = 0; i < N; i++) begin
          reached = 1'b0;
          for (int j = 0; j < N; j++) if (m_act[j] && m_edge[j][i]) reached = 1'b1;
          nv[i] = m_match[i][symbol] && ((m_sod && m_sod_st[i]) || m_all_st[i] || reached);
        end
        rv = nv & m_mask;
        if (rv != 4'd0) begin
          if (m_q.size() - (pop ? 1 : 0) < FD) begin
            push = 1'b1; e.vec = rv; e.ofs = m_ofs;
          end else begin
            m_ovf = 1'b1;
          end
        end
        m_act = nv;
        m_ofs = (m_ofs + 1) % 16;
        m_sod = 1'b0;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(e);
    end
  endtask

  task automatic check_model();
    chk("active", 32'(active_state), 32'(m_act));
    chk("rpt_valid", 32'(rpt_valid), 32'(m_q.size() > 0));
    chk("overflow", 32'(rpt_overflow), 32'(m_ovf));
    if (m_q.size() > 0) begin
      chk("rpt_vec", 32'(rpt_vec), 32'(m_q[0].vec));
      chk("rpt_offset", 32'(rpt_offset), 32'(m_q[0].ofs));
    end
  endtask

  task automatic drive(input logic r, input logic sv, input logic [7:0] sym, input logic fl,
                       input logic rr, input logic we, input logic [1:0] sel,
                       input logic [7:0] row, input logic [1:0] col, input logic [1:0] val);
    run = r; sym_valid = sv; symbol = sym; flush = fl; rpt_ready = rr;
    cfg_we = we; cfg_sel = sel; cfg_row = row; cfg_col = col; cfg_val = val;
    model_clock();
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [7:0] row, input logic [1:0] col,
                     input logic [1:0] val);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, sel, row, col, val);
  endtask

  task automatic step(input logic [7:0] sym, input logic rr);
    drive(1'b1, 1'b1, sym, 1'b0, rr, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 1'b0, 8'h00, 1'b0, rr, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
  endtask

  task automatic do_flush();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
  endtask

  task automatic do_reset(input logic r, input logic sv, input logic fl, input logic we);
    reset = 1'b0; run = r; sym_valid = sv; symbol = 8'h7E; flush = fl; rpt_ready = 1'b0;
    cfg_we = we; cfg_sel = 2'd0; cfg_row = 8'h7E; cfg_col = 2'd0; cfg_val = 2'd1;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1; run = 1'b0; sym_valid = 1'b0; flush = 1'b0; cfg_we = 1'b0;
    check_model();
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; sym_valid = 1'b0; symbol = 8'h00; flush = 1'b0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_row = 8'h00; cfg_col = 2'd0; cfg_val = 2'd0;
    rpt_ready = 1'b0;

    tbl[0] = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010, 4'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010, 4'd1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'd0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd0, 1'b0};

    @(posedge clk); #1;
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_active", 32'(active_state), 32'd0);
    chk("reset_valid", 32'(rpt_valid), 32'd0);

    // Two-state chain s0 -(05)-> s1 -(20)-> report
    cfg(2'd2, 8'd0, 2'd0, 2'b01);
    cfg(2'd0, 8'h05, 2'd0, 2'b01);
    cfg(2'd1, 8'd0, 2'd1, 2'b01);
    cfg(2'd0, 8'h20, 2'd1, 2'b01);
    cfg(2'd3, 8'd1, 2'd0, 2'b01);
    for (int t = 0; t < 6; t++) begin
      drive(tbl[t].run, tbl[t].sv, tbl[t].sym, tbl[t].fl, tbl[t].rr,
            1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
      chk($sformatf("tbl%0d_act", t), 32'(active_state), 32'(tbl[t].e_act));
      chk($sformatf("tbl%0d_valid", t), 32'(rpt_valid), 32'(tbl[t].e_rv));
      chk($sformatf("tbl%0d_ovf", t), 32'(rpt_overflow), 32'(tbl[t].e_ovf));
      if (tbl[t].e_rv) begin
        chk($sformatf("tbl%0d_vec", t), 32'(rpt_vec), 32'(tbl[t].e_vec));
        chk($sformatf("tbl%0d_ofs", t), 32'(rpt_offset), 32'(tbl[t].e_ofs));
      end
    end

    // Start-of-data only: a late 05 must not start s0
    step(8'h07, 1'b0); step(8'h05, 1'b0); step(8'h20, 1'b0);
    chk("sod_only_valid", 32'(rpt_valid), 32'd0);
    cfg(2'd2, 8'd0, 2'd0, 2'b11);
    do_flush();
    step(8'h07, 1'b0); step(8'h05, 1'b0); step(8'h20, 1'b0);
    chk("all_start_valid", 32'(rpt_valid), 32'd1);
    chk("all_start_vec", 32'(rpt_vec), 32'h2);
    chk("all_start_ofs", 32'(rpt_offset), 32'd2);
    idle(1'b1);
    chk("all_start_pop", 32'(rpt_valid), 32'd0);

    // Self-loop s2 on 10..1F, two-deep FIFO overflow
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    cfg(2'd1, 8'd2, 2'd2, 2'b01);
    for (int s = 8'h10; s <= 8'h1F; s++) cfg(2'd0, 8'(s), 2'd2, 2'b01);
    cfg(2'd2, 8'd2, 2'd0, 2'b10);
    cfg(2'd3, 8'd2, 2'd0, 2'b01);
    step(8'h11, 1'b0); step(8'h12, 1'b0);
    chk("loop_active", 32'(active_state), 32'h4);
    step(8'h13, 1'b0);
    chk("ovf_valid", 32'(rpt_valid), 32'd1);
    chk("ovf_vec", 32'(rpt_vec), 32'h4);
    chk("ovf_head_ofs", 32'(rpt_offset), 32'd0);
    chk("ovf_flag", 32'(rpt_overflow), 32'd1);
    idle(1'b1);
    chk("ovf_second_ofs", 32'(rpt_offset), 32'd1);

    // Full FIFO with a simultaneous pop accepts the new entry
    do_flush();
    step(8'h11, 1'b0); step(8'h12, 1'b0); step(8'h13, 1'b1);
    chk("fullpop_ovf", 32'(rpt_overflow), 32'd0);
    chk("fullpop_head", 32'(rpt_offset), 32'd1);
    idle(1'b1);
    chk("fullpop_next", 32'(rpt_offset), 32'd2);
    idle(1'b1);
    chk("fullpop_empty", 32'(rpt_valid), 32'd0);

    // cfg_we while running is ignored
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h30, 2'd2, 2'b01);
    step(8'h30, 1'b0);
    chk("cfg_run_ignored", 32'(active_state), 32'd0);

    // Flush beats a simultaneous step; next step is start-of-data
    cfg(2'd2, 8'd0, 2'd0, 2'b01);
    cfg(2'd0, 8'h05, 2'd0, 2'b01);
    cfg(2'd3, 8'd0, 2'd0, 2'b01);
    step(8'h11, 1'b0);
    drive(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
    chk("flush_act", 32'(active_state), 32'd0);
    chk("flush_valid", 32'(rpt_valid), 32'd0);
    step(8'h05, 1'b0);
    chk("flush_sod_vec", 32'(rpt_vec), 32'h1);
    chk("flush_sod_ofs", 32'(rpt_offset), 32'd0);

    // Offset wrap: 17th step reports offset 0
    do_flush();
    cfg(2'd2, 8'd3, 2'd0, 2'b10);
    cfg(2'd0, 8'h7E, 2'd3, 2'b01);
    cfg(2'd3, 8'd3, 2'd0, 2'b01);
    for (int k = 0; k < 16; k++) step(8'h00, 1'b0);
    step(8'h7E, 1'b0);
    chk("wrap_valid", 32'(rpt_valid), 32'd1);
    chk("wrap_vec", 32'(rpt_vec), 32'h8);
    chk("wrap_ofs", 32'(rpt_offset), 32'd0);
    step(8'h7E, 1'b0);

    // Reset overrides step, flush and pending reports
    do_reset(1'b1, 1'b1, 1'b1, 1'b1);
    chk("midreset_act", 32'(active_state), 32'd0);
    chk("midreset_valid", 32'(rpt_valid), 32'd0);
    chk("midreset_ovf", 32'(rpt_overflow), 32'd0);
    step(8'h7E, 1'b0);
    chk("midreset_cfg_cleared", 32'(active_state), 32'd0);

    // Randomized configuration and traffic against the reference model
    do_reset(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < 8; s++) cfg(2'd0, 8'(s), 2'(i), 2'($urandom_range(0, 1)));
      for (int j = 0; j < N; j++) cfg(2'd1, 8'(j), 2'(i), 2'($urandom_range(0, 2) == 0));
      cfg(2'd2, 8'(i), 2'd0, {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))});
      cfg(2'd3, 8'(i), 2'd0, 2'($urandom_range(0, 1)));
    end
    for (int c = 0; c < 400; c++) begin
      logic r, we;
      logic [1:0] sel;
      r   = 1'($urandom_range(0, 4) != 0);
      we  = !r && ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      drive(r, 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 7)),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), we, sel,
            (sel == 2'd0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ltl_nfa_monitor.md
LTL_NFA_MONITOR -- requirements
Module: ltl_nfa_monitor

Interface
REQ-001 SHALL have parameter N_STATES, default 16: number of STEs (1..64).
REQ-002 SHALL have parameter SYM_W, default 8: symbol width; match table depth 2^SYM_W.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: report FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter OFS_W, default 16: symbol offset counter width.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port run  in  1  enables symbol consumption; config writes only while low.
REQ-008 SHALL have port sym_valid  in  1  symbol present this cycle.
REQ-009 SHALL have port symbol  in  SYM_W  input symbol.
REQ-010 SHALL have port flush  in  1  clear active states, offset, FIFO, overflow; configuration kept.
REQ-011 SHALL have port cfg_we  in  1  configuration write strobe.
REQ-012 SHALL have port cfg_sel  in  2  target: 0 match, 1 edge, 2 start, 3 report.
REQ-013 SHALL have port cfg_row  in  max(SYM_W,log2 N_STATES)  symbol (match) or source state (edge); state index (start/report).
REQ-014 SHALL have port cfg_col  in  log2 N_STATES  state index (match) or destination state (edge).
REQ-015 SHALL have port cfg_val  in  2  bit value; bit1 used only for start (bit0 start-of-data, bit1 all-input).
REQ-016 SHALL have port active_state  out  N_STATES  registered STE activity vector.
REQ-017 SHALL have ports rpt_valid out 1 / rpt_ready in 1: report FIFO valid/ready handshake.
REQ-018 SHALL have ports rpt_vec out N_STATES / rpt_offset out OFS_W: FIFO head payload.
REQ-019 SHALL have port rpt_overflow  out  1  sticky: a report was dropped.

Function
REQ-020 SHALL hold tables: match[N][2^SYM_W], edge[N][N], sod_start[N], all_start[N], rpt_mask[N], each 1 bit.
REQ-021 SHALL apply cfg_we only when run=0; cfg_we with run=1 ignored, no state change.
REQ-022 SHALL define step = run & sym_valid; no step -> active_state, offset, sod flag held.
REQ-023 SHALL on step compute nxt[i] = match[i][symbol] & ((sod & sod_start[i]) | all_start[i] | OR_j(active_state[j] & edge[j][i])), register into active_state same edge.
REQ-024 SHALL set sod=1 after reset or flush; cleared by first step; sod holds across run=0.
REQ-025 SHALL increment offset on every step, wrapping 2^OFS_W-1 -> 0; report offset is the pre-increment value.
REQ-026 SHALL push {nxt & rpt_mask, offset} into FIFO on a step where (nxt & rpt_mask) != 0.
REQ-027 SHALL expose FIFO head registered; rpt_valid=1 iff FIFO non-empty; pop when rpt_valid & rpt_ready.
REQ-028 SHALL accept a push when full only if a pop occurs same cycle; otherwise drop entry, set rpt_overflow.
REQ-029 SHALL on push into empty FIFO assert rpt_valid the cycle after the step (one-cycle latency).
REQ-030 SHALL keep rpt_vec/rpt_offset stable while rpt_valid=1 and rpt_ready=0.
REQ-031 SHALL give flush priority over step and push in the same cycle: step ignored, FIFO emptied, overflow cleared, sod=1.
REQ-032 SHALL, for a self-edge, keep a state active while it keeps matching (loop semantics).

Reset
REQ-033 SHALL on reset=0 at a rising edge clear all tables, active_state=0, offset=0, FIFO empty, rpt_valid=0, rpt_overflow=0, sod=1.
REQ-034 SHALL let reset mid-stream discard pending reports and override cfg_we, step and flush.

Verification
REQ-035 N=4: s0 sod_start, match[0][0x05], edge 0->1, match[1][0x20], rpt_mask[1]; stream 05,20 -> report {vec=0010, offset=1}, rpt_valid one cycle after second step.
REQ-036 Same config, stream 07,05,20 -> no report (s0 start-of-data only); with all_start[0] set -> report offset=2.
REQ-037 Self-loop s2 (edge 2->2, match 0x10-0x1F, all_start, report): stream 11,12,13 with rpt_ready=0, FIFO_DEPTH=2 -> 2 entries (offsets 0,1), third dropped, rpt_overflow=1.
REQ-038 FIFO full, rpt_ready=1 on same cycle as new report -> no drop, overflow stays 0, order preserved.
REQ-039 cfg_we with run=1 -> table unchanged; flush with sym_valid same cycle -> active_state=0, offset=0, next step treated as start-of-data.
REQ-040 OFS_W=4: 17 steps, report on last -> rpt_offset=0 (wrap); reset=0 mid-stream -> all outputs zero next cycle.
